// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, registered syncs, blanking, pixel-load strobe,
// incremental frame-buffer addressing with line repeat and vblank-latched page select.
module video_timing_gen #(
  parameter int                H_VISIBLE        = 128,
  parameter int                H_TOTAL          = 168,
  parameter int                H_SYNC_START     = 131,
  parameter int                H_SYNC_END       = 147,
  parameter int                V_VISIBLE_START  = 42,
  parameter int                V_VISIBLE_END    = 725,
  parameter int                V_TOTAL          = 806,
  parameter int                V_SYNC_START     = 771,
  parameter int                V_SYNC_END       = 776,
  parameter int                PIXEL_LATENCY    = 1,
  parameter int                LINE_REPEAT_LOG2 = 1,
  parameter int                BYTES_PER_LINE   = 64,
  parameter bit                HSYNC_ACTIVE     = 1'b0,
  parameter bit                VSYNC_ACTIVE     = 1'b0,
  parameter int                ADDR_W           = 22,
  parameter logic [ADDR_W-1:0] PAGE0_BASE       = 22'h3F2700,
  parameter logic [ADDR_W-1:0] PAGE1_BASE       = 22'h3FA700
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              clk_en,
  input  logic [1:0]        busCycle,
  input  logic              vid_alt,
  output logic [ADDR_W-1:0] videoAddr,
  output logic              hsync,
  output logic              vsync,
  output logic              _hblank,
  output logic              _vblank,
  output logic              loadPixels,
  output logic              vbl_irq,
  output logic [15:0]       frame_count,
  output logic              page
);

  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int RW = (LINE_REPEAT_LOG2 > 0) ? LINE_REPEAT_LOG2 : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] HB_END   = XW'(H_VISIBLE + PIXEL_LATENCY);
  localparam logic [XW-1:0] HS_FIRST = XW'(H_SYNC_START + PIXEL_LATENCY);
  localparam logic [XW-1:0] HS_LAST  = XW'(H_SYNC_END + PIXEL_LATENCY);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] YV_FIRST = YW'(V_VISIBLE_START);
  localparam logic [YW-1:0] YV_LAST  = YW'(V_VISIBLE_END);
  localparam logic [YW-1:0] VS_FIRST = YW'(V_SYNC_START);
  localparam logic [YW-1:0] VS_LAST  = YW'(V_SYNC_END);

  generate
    if ((H_SYNC_END + PIXEL_LATENCY >= H_TOTAL) || (V_VISIBLE_END >= V_TOTAL) ||
        (V_SYNC_END >= V_TOTAL) || ((H_VISIBLE % 4) != 0)) begin : g_param_check
      $error("video_timing_gen: illegal timing parameters");
    end
  endgenerate

  logic [XW-1:0]     xpos_reg, xpos_next;
  logic [YW-1:0]     ypos_reg, ypos_next, ypos_inc;
  logic              hsync_reg, hsync_next;
  logic              vsync_reg, vsync_next;
  logic              vbl_irq_reg, vbl_irq_next;
  logic              page_reg, page_next;
  logic [15:0]       frame_count_reg, frame_count_next;
  logic [ADDR_W-1:0] line_off_reg, line_off_next;
  logic [RW-1:0]     rep_cnt_reg, rep_cnt_next;
  logic              endline, y_wrap, y_visible, rep_wrap;

  assign endline   = (xpos_reg == X_LAST);
  assign y_wrap    = (ypos_reg == Y_LAST);
  assign ypos_inc  = y_wrap ? '0 : ypos_reg + YW'(1);
  assign y_visible = (ypos_reg >= YV_FIRST) && (ypos_reg <= YV_LAST);
  // With no repeat every visible line advances the fetch pointer.
  assign rep_wrap  = (LINE_REPEAT_LOG2 == 0) || (rep_cnt_reg == '1);

  always_comb begin
    xpos_next        = xpos_reg;
    ypos_next        = ypos_reg;
    frame_count_next = frame_count_reg;
    page_next        = page_reg;
    line_off_next    = line_off_reg;
    rep_cnt_next     = rep_cnt_reg;
    hsync_next       = ((xpos_reg >= HS_FIRST) && (xpos_reg <= HS_LAST)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    vsync_next       = ((ypos_reg >= VS_FIRST) && (ypos_reg <= VS_LAST)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    vbl_irq_next     = endline && (ypos_reg == YV_LAST);

    if (endline) begin
      xpos_next = '0;
      ypos_next = ypos_inc;
      if (y_wrap)
        frame_count_next = frame_count_reg + 16'd1;
      if (ypos_reg == YV_LAST)
        page_next = vid_alt;
      if (ypos_inc == YV_FIRST) begin
        line_off_next = '0;
        rep_cnt_next  = '0;
      end else if (y_visible) begin
        rep_cnt_next = rep_cnt_reg + RW'(1);
        if (rep_wrap)
          line_off_next = line_off_reg + ADDR_W'(BYTES_PER_LINE);
      end
    end else if ((xpos_reg != '0) || (busCycle == 2'd0)) begin
      // At the start of a line, wait for the video bus slot before moving on.
      xpos_next = xpos_reg + XW'(1);
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      xpos_reg        <= '0;
      ypos_reg        <= '0;
      hsync_reg       <= ~HSYNC_ACTIVE;
      vsync_reg       <= ~VSYNC_ACTIVE;
      vbl_irq_reg     <= 1'b0;
      frame_count_reg <= '0;
      page_reg        <= 1'b0;
      line_off_reg    <= '0;
      rep_cnt_reg     <= '0;
    end else if (clk_en) begin
      xpos_reg        <= xpos_next;
      ypos_reg        <= ypos_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      vbl_irq_reg     <= vbl_irq_next;
      frame_count_reg <= frame_count_next;
      page_reg        <= page_next;
      line_off_reg    <= line_off_next;
      rep_cnt_reg     <= rep_cnt_next;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign vbl_irq     = vbl_irq_reg;
  assign frame_count = frame_count_reg;
  assign page        = page_reg;
  assign _hblank     = (xpos_reg < HB_END);
  assign _vblank     = y_visible;
  assign loadPixels  = _hblank & _vblank & (busCycle == 2'd0);
  assign videoAddr   = (page_reg ? PAGE1_BASE : PAGE0_BASE) + line_off_reg +
                       ADDR_W'({xpos_reg[XW-1:2], 1'b0});

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench: a full-size and a small-geometry instance share stimulus
// and are compared every cycle against an arithmetic raster model.
module tb_video_timing_gen;

  localparam int N_CYC   = 12000;
  localparam int RST_CYC = 1000;

  typedef struct {
    int hvis, htot, hss, hse, vvs, vve, vtot, vss, vse, lat, rep, bpl;
    bit hsa, vsa;
    logic [21:0] p0, p1;
  } geom_t;

  typedef struct {
    int x, y, fc;
    bit pg, hs, vs, irq, seen;
  } mstate_t;

  typedef struct packed {
    logic [21:0] addr;
    logic        hs, vs, hb, vb, ld, irq;
    logic [15:0] fc;
    logic        pg;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n, clk_en, vid_alt;
  logic [1:0] bus_cycle;
  always #5 clk = ~clk;

  logic [21:0] a_addr, b_addr;
  logic a_hs, a_vs, a_hb, a_vb, a_ld, a_irq, a_pg;
  logic b_hs, b_vs, b_hb, b_vb, b_ld, b_irq, b_pg;
  logic [15:0] a_fc, b_fc;

  video_timing_gen dut_a (
    .clk(clk), ._reset(rst_n), .clk_en(clk_en), .busCycle(bus_cycle), .vid_alt(vid_alt),
    .videoAddr(a_addr), .hsync(a_hs), .vsync(a_vs), ._hblank(a_hb), ._vblank(a_vb),
    .loadPixels(a_ld), .vbl_irq(a_irq), .frame_count(a_fc), .page(a_pg)
  );

  video_timing_gen #(
    .H_VISIBLE(16), .H_TOTAL(24), .H_SYNC_START(18), .H_SYNC_END(20),
    .V_VISIBLE_START(3), .V_VISIBLE_END(12), .V_TOTAL(16), .V_SYNC_START(13), .V_SYNC_END(14),
    .PIXEL_LATENCY(1), .LINE_REPEAT_LOG2(2), .BYTES_PER_LINE(64),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1)
  ) dut_b (
    .clk(clk), ._reset(rst_n), .clk_en(clk_en), .busCycle(bus_cycle), .vid_alt(vid_alt),
    .videoAddr(b_addr), .hsync(b_hs), .vsync(b_vs), ._hblank(b_hb), ._vblank(b_vb),
    .loadPixels(b_ld), .vbl_irq(b_irq), .frame_count(b_fc), .page(b_pg)
  );

  geom_t   ga, gb;
  mstate_t sa, sb;
  obs_t    q_a[$], q_b[$];
  int      errors = 0;
  int      checks = 0;
  int      cyc_now = 0;

  function automatic mstate_t reset_state(geom_t g);
    mstate_t s;
    s.x = 0; s.y = 0; s.fc = 0; s.pg = 1'b0;
    s.hs = !g.hsa; s.vs = !g.vsa; s.irq = 1'b0; s.seen = 1'b0;
    return s;
  endfunction

  function automatic bit in_vis(geom_t g, int y);
    return (y >= g.vvs) && (y <= g.vve);
  endfunction

  // Expected outputs straight from the raster rules: line offset is the number of
  // completed repeat groups since the first visible line, times the pitch.
  function automatic obs_t expect_out(geom_t g, mstate_t s, logic [1:0] bus);
    obs_t o;
    longint groups, sum;
    if (in_vis(g, s.y))  groups = longint'((s.y - g.vvs) >> g.rep);
    else if (s.seen)     groups = longint'((g.vve - g.vvs + 1) >> g.rep);
    else                 groups = 0;
    sum    = longint'(s.pg ? g.p1 : g.p0) + groups * g.bpl + longint'((s.x / 4) * 2);
    o.addr = 22'(sum);
    o.hs   = s.hs;
    o.vs   = s.vs;
    o.hb   = (s.x < g.hvis + g.lat);
    o.vb   = in_vis(g, s.y);
    o.ld   = o.hb && o.vb && (bus == 2'd0);
    o.irq  = s.irq;
    o.fc   = 16'(s.fc);
    o.pg   = s.pg;
    return o;
  endfunction

  function automatic mstate_t step(geom_t g, mstate_t s, logic [1:0] bus, logic alt);
    mstate_t n;
    bit endl;
    n    = s;
    endl = (s.x == g.htot - 1);
    n.hs  = (s.x >= g.hss + g.lat && s.x <= g.hse + g.lat) ? g.hsa : !g.hsa;
    n.vs  = (s.y >= g.vss && s.y <= g.vse) ? g.vsa : !g.vsa;
    n.irq = endl && (s.y == g.vve);
    if (endl) begin
      n.x = 0;
      if (s.y == g.vve) n.pg = alt;
      if (s.y == g.vtot - 1) begin
        n.y  = 0;
        n.fc = (s.fc + 1) % 65536;
      end else begin
        n.y = s.y + 1;
      end
      if (in_vis(g, n.y)) n.seen = 1'b1;
    end else if (!(s.x == 0 && bus != 2'd0)) begin
      n.x = s.x + 1;
    end
    return n;
  endfunction

  function automatic obs_t obs_a();
    return {a_addr, a_hs, a_vs, a_hb, a_vb, a_ld, a_irq, a_fc, a_pg};
  endfunction

  function automatic obs_t obs_b();
    return {b_addr, b_hs, b_vs, b_hb, b_vb, b_ld, b_irq, b_fc, b_pg};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got addr=%h hs=%b vs=%b hb=%b vb=%b ld=%b irq=%b fc=%0d pg=%b want addr=%h hs=%b vs=%b hb=%b vb=%b ld=%b irq=%b fc=%0d pg=%b",
               name, cyc_now, act.addr, act.hs, act.vs, act.hb, act.vb, act.ld, act.irq, act.fc, act.pg,
               exp.addr, exp.hs, exp.vs, exp.hb, exp.vb, exp.ld, exp.irq, exp.fc, exp.pg);
    end
  endtask

  // Monitor: one scoreboard entry per DUT per cycle, sampled away from the active edge.
  initial begin
    obs_t exp_o, act_o;
    logic prev_irq = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (q_a.size() == 0 || q_b.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_underflow cyc=%0d got empty queue want entry", cyc_now);
      end else begin
        exp_o = q_a.pop_front();
        check("dut_a", obs_a(), exp_o);
        exp_o = q_b.pop_front();
        act_o = obs_b();
        check("dut_b", act_o, exp_o);
        if (act_o.irq && !prev_irq)
          $display("frame: dut_b vblank irq at cyc=%0d frames=%0d page=%0d", cyc_now, act_o.fc, act_o.pg);
        prev_irq = act_o.irq;
      end
    end
  end

  initial begin
    ga = '{hvis:128, htot:168, hss:131, hse:147, vvs:42, vve:725, vtot:806, vss:771, vse:776,
           lat:1, rep:1, bpl:64, hsa:1'b0, vsa:1'b0, p0:22'h3F2700, p1:22'h3FA700};
    gb = '{hvis:16, htot:24, hss:18, hse:20, vvs:3, vve:12, vtot:16, vss:13, vse:14,
           lat:1, rep:2, bpl:64, hsa:1'b1, vsa:1'b1, p0:22'h3F2700, p1:22'h3FA700};
    sa = reset_state(ga);
    sb = reset_state(gb);
    rst_n = 1'b0; clk_en = 1'b0; bus_cycle = 2'd0; vid_alt = 1'b0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      cyc_now = cyc;
      if (cyc == 4 || cyc == RST_CYC + 3) rst_n = 1'b1;
      clk_en    = ($urandom_range(0, 7) != 0);
      bus_cycle = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 63) == 0) vid_alt = ~vid_alt;
      q_a.push_back(expect_out(ga, sa, bus_cycle));
      q_b.push_back(expect_out(gb, sb, bus_cycle));
      if (rst_n && clk_en) begin
        sa = step(ga, sa, bus_cycle, vid_alt);
        sb = step(gb, sb, bus_cycle, vid_alt);
      end
      if (cyc == RST_CYC) begin
        // Mid-frame reset between clock edges must clear state without waiting for clk.
        #2 rst_n = 1'b0;
        #1;
        sa = reset_state(ga);
        sb = reset_state(gb);
        check("async_reset_a", obs_a(), expect_out(ga, sa, bus_cycle));
        check("async_reset_b", obs_b(), expect_out(gb, sb, bus_cycle));
      end
    end
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 1024x768 video timer.
- Generates h/v sync, blanking, the pixel-load strobe and the frame-buffer word address for any raster geometry at clk_en rate (one tick = 4 output pixels).
- Adds tear-free double-buffer page select (latched at vblank entry), a vertical-blank interrupt pulse, a frame counter and configurable sync polarity and line repeat.
- Sits between the bus-cycle sequencer and the video shift register.

Parameters:
- H_VISIBLE, 128, visible ticks per line.
- H_TOTAL, 168, total ticks per line.
- H_SYNC_START, 131, first hsync tick, before latency.
- H_SYNC_END, 147, last hsync tick, inclusive, before latency.
- V_VISIBLE_START, 42, first visible line.
- V_VISIBLE_END, 725, last visible line, inclusive.
- V_TOTAL, 806, total lines per frame.
- V_SYNC_START, 771, first vsync line.
- V_SYNC_END, 776, last vsync line, inclusive.
- PIXEL_LATENCY, 1, ticks from xpos==0 to first pixel out.
- LINE_REPEAT_LOG2, 1, each fetched line shown 2^N times.
- BYTES_PER_LINE, 64, frame-buffer pitch.
- HSYNC_ACTIVE, 0, asserted level of hsync.
- VSYNC_ACTIVE, 0, asserted level of vsync.
- ADDR_W, 22, address width.
- PAGE0_BASE, 22'h3F2700, main-page base.
- PAGE1_BASE, 22'h3FA700, alternate-page base.

Ports:
- clk  in  1  system clock.
- _reset  in  1  asynchronous active-low reset.
- clk_en  in  1  tick enable; all state advances only when high.
- busCycle  in  2  bus phase; 0 = video slot.
- vid_alt  in  1  requested page (1 = PAGE1).
- videoAddr  out  ADDR_W  frame-buffer byte address (even).
- hsync  out  1  registered horizontal sync.
- vsync  out  1  registered vertical sync.
- _hblank  out  1  low during horizontal blank.
- _vblank  out  1  low during vertical blank.
- loadPixels  out  1  load shift register this tick.
- vbl_irq  out  1  one-tick pulse at vblank entry.
- frame_count  out  16  frames completed, wraps.
- page  out  1  page currently scanned out.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. With clk_en low, every register holds.
- Reset values: xpos=0, ypos=0, hsync=~HSYNC_ACTIVE, vsync=~VSYNC_ACTIVE, vbl_irq=0, frame_count=0, page=0, line_off=0, rep_cnt=0.
- xpos: width ceil(log2(H_TOTAL)).
  - Wraps to 0 when xpos==H_TOTAL-1 (endline).
  - While xpos==0 and busCycle!=0, holds at 0 (phase lock).
  - Otherwise increments.
- ypos:
  - On endline, increments.
  - Wraps to 0 after V_TOTAL-1.
  - frame_count increments on that same tick.
- Sync (registered, one tick late):
  - hsync = HSYNC_ACTIVE when H_SYNC_START+PIXEL_LATENCY <= xpos <= H_SYNC_END+PIXEL_LATENCY, else inverse.
  - vsync = VSYNC_ACTIVE when V_SYNC_START <= ypos <= V_SYNC_END, else inverse.
- Blanking (combinational):
  - _hblank = (xpos < H_VISIBLE+PIXEL_LATENCY).
  - _vblank = (V_VISIBLE_START <= ypos <= V_VISIBLE_END).
- loadPixels = _hblank & _vblank & (busCycle==0), combinational.
- Address (incremental, no multiplier):
  - videoAddr = (page ? PAGE1_BASE : PAGE0_BASE) + line_off + {xpos[..2], 1'b0}, modulo 2^ADDR_W.
  - xpos[..2] means xpos>>2.
  - On endline with next ypos==V_VISIBLE_START: line_off<=0, rep_cnt<=0.
  - On other endlines inside the visible range: rep_cnt increments. When rep_cnt wraps (all ones -> 0), line_off += BYTES_PER_LINE.
  - Outside the visible range, line_off holds.
- Page latch:
  - On endline with ypos==V_VISIBLE_END, page<=vid_alt.
  - vid_alt changes at any other time have no visible effect until then.
- vbl_irq: registered. High for exactly one clk_en tick following the endline where ypos==V_VISIBLE_END; low otherwise.
- Simultaneous events: frame wrap and endline coincide at ypos==V_TOTAL-1; ypos, frame_count and line state all update on that tick.
- Reset mid-frame: returns all state to reset values immediately. No vbl_irq is generated by reset.
- Parameter legality:
  - H_SYNC_END+PIXEL_LATENCY < H_TOTAL.
  - V_VISIBLE_END < V_TOTAL.
  - V_SYNC_END < V_TOTAL.
  - H_VISIBLE multiple of 4.
  - Violations are caught by an elaboration-time check.

Test Plan:
- Reset, clk_en=1, busCycle cycling 0..3 -> xpos reaches 167 then wraps to 0. Exactly 168 ticks per line; 806 lines per frame; frame_count=1 after first wrap.
- Hold busCycle=2 for 10 ticks while xpos==0 -> xpos stays 0, then resumes on the first tick with busCycle==0 and increments afterwards.
- Hsync: xpos=132 -> hsync low on the following tick; xpos=148 -> still low; xpos=149 -> high. Repeat with HSYNC_ACTIVE=1 -> inverted.
- Address with vid_alt=0 since reset:
  - ypos=42, xpos=0 -> 0x3F2700.
  - ypos=43, xpos=0 -> 0x3F2700.
  - ypos=44, xpos=0 -> 0x3F2740.
  - ypos=44, xpos=8 -> 0x3F2744.
- Page latch: set vid_alt=1 at ypos=300 -> videoAddr stays on PAGE0 through ypos=725. Then page=1 and vbl_irq pulses once; next frame ypos=42 address = 0x3FA700.
- Assert _reset at ypos=500, xpos=60 -> outputs take reset values asynchronously. After release, counting restarts from 0,0 with no vbl_irq until ypos 725 endline.
